grn_node_multi: RTL

- Parametrised successor to the two-copy GRN node. It holds NCH independent state registers, each WIDTH bits wide, for one gene of the network.
- Each channel samples its next-state function output on its own enable. A per-channel runtime delay sets the update period, so the register takes a new value on every (delay+1)-th enable.
- Adds per-channel update and change strobes and a saturating stability detector. The network controller uses these to stop a simulation run once the node has settled.
- Sits between the network's boolean-function (gata) logic and the controller. State outputs feed back into the function logic of other nodes.

---
 rtl/grn_pkg.sv | 17 +
 rtl/grn_chan.sv | 67 ++++++
 rtl/grn_node_multi.sv | 82 ++++++++
 3 files changed

// File: rtl/grn_pkg.sv
// Shared widths and bus slicing helpers for the GRN node.
// Imported by grn_chan and grn_node_multi.
package grn_pkg;

  localparam int WIDTH_DEF  = 1;
  localparam int DIV_W_DEF  = 4;
  localparam int STAB_W_DEF = 8;

  // Low bit of slice c in a flattened bus of w-bit fields.
  function automatic int lo(
    input int c,
    input int w
  );
    return c * w;
  endfunction

endpackage

// File: rtl/grn_chan.sv
// One GRN state channel: state reg, delay countdown, upd/chg strobes.
// Ports: clk, rst, reset_nos, en, delay, init_state, next_st -> st, upd, chg, upd_now, chg_now.
module grn_chan
  import grn_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             reset_nos,
  input  logic             en,
  input  logic [DIV_W-1:0] delay,
  input  logic [WIDTH-1:0] init_state,
  input  logic [WIDTH-1:0] next_st,
  output logic [WIDTH-1:0] st,
  output logic             upd,
  output logic             chg,
  output logic             upd_now,
  output logic             chg_now
);

  logic [WIDTH-1:0] st_q, st_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             upd_q, upd_d;
  logic             chg_q, chg_d;

  // upd_now/chg_now feed the shared stability counter in the top.
  always_comb begin
    upd_now = en && (cnt_q == '0);
    chg_now = (next_st != st_q);
    st_d    = st_q;
    cnt_d   = cnt_q;
    upd_d   = 1'b0;
    chg_d   = 1'b0;
    if (reset_nos) begin
      st_d  = init_state;
      cnt_d = '0;
    end else if (upd_now) begin
      st_d  = next_st;
      cnt_d = delay;
      upd_d = 1'b1;
      chg_d = chg_now;
    end else if (en) begin
      cnt_d = cnt_q - DIV_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q  <= '0;
      cnt_q <= '0;
      upd_q <= 1'b0;
      chg_q <= 1'b0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
      upd_q <= upd_d;
      chg_q <= chg_d;
    end
  end

  assign st  = st_q;
  assign upd = upd_q;
  assign chg = chg_q;

endmodule

// File: rtl/grn_node_multi.sv
// Multi-channel GRN node with per-channel delay and a stability detector.
// Ports: clk, rst, start, reset_nos, init_state, start_ch, delay, next_st, stab_th -> st, upd, chg, stable.
module grn_node_multi
  import grn_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int NCH    = 2,
  parameter int DIV_W  = DIV_W_DEF,
  parameter int STAB_W = STAB_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 reset_nos,
  input  logic [WIDTH-1:0]     init_state,
  input  logic [NCH-1:0]       start_ch,
  input  logic [NCH*DIV_W-1:0] delay,
  input  logic [NCH*WIDTH-1:0] next_st,
  input  logic [STAB_W-1:0]    stab_th,
  output logic [NCH*WIDTH-1:0] st,
  output logic [NCH-1:0]       upd,
  output logic [NCH-1:0]       chg,
  output logic                 stable
);

  logic [NCH-1:0]    en;
  logic [NCH-1:0]    upd_now;
  logic [NCH-1:0]    chg_now;
  logic [STAB_W-1:0] stab_q, stab_d;
  logic              any_upd;
  logic              any_chg;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    assign en[c] = start & start_ch[c] & ~reset_nos;

    grn_chan #(
      .WIDTH (WIDTH),
      .DIV_W (DIV_W)
    ) u_chan (
      .clk        (clk),
      .rst        (rst),
      .reset_nos  (reset_nos),
      .en         (en[c]),
      .delay      (delay[lo(c, DIV_W) +: DIV_W]),
      .init_state (init_state),
      .next_st    (next_st[lo(c, WIDTH) +: WIDTH]),
      .st         (st[lo(c, WIDTH) +: WIDTH]),
      .upd        (upd[c]),
      .chg        (chg[c]),
      .upd_now    (upd_now[c]),
      .chg_now    (chg_now[c])
    );
  end

  // One step per cycle no matter how many channels update together.
  always_comb begin
    any_upd = |upd_now;
    any_chg = |(upd_now & chg_now);
    stab_d  = stab_q;
    if (reset_nos) begin
      stab_d = '0;
    end else if (any_upd) begin
      if (any_chg) begin
        stab_d = '0;
      end else if (stab_q != '1) begin
        stab_d = stab_q + STAB_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stab_q <= '0;
    end else begin
      stab_q <= stab_d;
    end
  end

  // Gated by rst so a zero threshold still reads unstable during reset.
  assign stable = ~rst & (stab_q >= stab_th);

endmodule
